// File: rtl/ball_box_if.sv
// Ball box handshake toward the screen drawer: one box per frame on valid/ready.
interface ball_box_if;
  logic       m_valid;
  logic       m_ready;
  logic [8:0] box_x;
  logic [8:0] box_y;
  logic [2:0] out_color;

  modport master (output m_valid, box_x, box_y, out_color, input m_ready);
  modport slave  (input m_valid, box_x, box_y, out_color, output m_ready);
endinterface

// File: rtl/ball_location_processor.sv
// Pong ball mover: one position update per frame transfer, wall/paddle bounces,
// scoring with respawn, and a sticky game-over that freezes play until reset.
module ball_location_processor #(
  parameter logic [8:0]  BALL_SIZE        = 9'd4,
  parameter logic [8:0]  SCREEN_WIDTH     = 9'd320,
  parameter logic [8:0]  SCREEN_HEIGHT    = 9'd240,
  parameter logic [8:0]  LEFT_PADDLE_X    = 9'd0,
  parameter logic [8:0]  RIGHT_PADDLE_X   = 9'd310,
  parameter logic [8:0]  PADDLE_W         = 9'd10,
  parameter logic [8:0]  PADDLE_H         = 9'd48,
  parameter logic [8:0]  START_X          = 9'd158,
  parameter logic [8:0]  START_Y          = 9'd118,
  parameter logic [3:0]  WIN_SCORE        = 4'd7,
  parameter logic [31:0] FRAME_RATE_COUNT = 32'd3333332
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       in_color,
  input  logic [8:0]       left_paddle_y,
  input  logic [8:0]       right_paddle_y,
  ball_box_if.master       bus,
  output logic [3:0]       score_left,
  output logic [3:0]       score_right,
  output logic             point_scored,
  output logic             game_over
);

  typedef enum logic [1:0] {
    S_WAIT_TRANSACTION,
    S_UPDATE_POSITION,
    S_WAIT_FRAME_RATE_COUNT
  } state_e;

  state_e      state_q;
  logic        valid_q;
  logic [31:0] cnt_q;
  logic [8:0]  x_q, y_q;
  logic        dx_q, dy_q;
  logic [3:0]  sl_q, sr_q;
  logic        ps_q, go_q;

  logic [8:0]  x_d, y_d;
  logic        dx_d, dy_d;
  logic [3:0]  sl_d, sr_d;
  logic        ps_d;

  // 10-bit geometry so edge sums never wrap
  logic [9:0] x_right, y_bot;
  logic       ovl_left, ovl_right;

  assign x_right   = {1'b0, x_q} + {1'b0, BALL_SIZE};
  assign y_bot     = {1'b0, y_q} + {1'b0, BALL_SIZE};
  assign ovl_left  = (y_bot > {1'b0, left_paddle_y}) &&
                     ({1'b0, y_q} < ({1'b0, left_paddle_y} + {1'b0, PADDLE_H}));
  assign ovl_right = (y_bot > {1'b0, right_paddle_y}) &&
                     ({1'b0, y_q} < ({1'b0, right_paddle_y} + {1'b0, PADDLE_H}));

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    sl_d = sl_q;
    sr_d = sr_q;
    ps_d = 1'b0;

    if (dy_q) begin
      if (y_bot == {1'b0, SCREEN_HEIGHT}) dy_d = 1'b0;
      else                                y_d  = y_q + 9'd1;
    end else begin
      if (y_q == 9'd0) dy_d = 1'b1;
      else             y_d  = y_q - 9'd1;
    end

    if (dx_q) begin
      if (x_right == {1'b0, RIGHT_PADDLE_X} && ovl_right) dx_d = 1'b0;
      else if (x_right == {1'b0, SCREEN_WIDTH}) begin
        sl_d = sl_q + 4'd1;
        ps_d = 1'b1;
      end else x_d = x_q + 9'd1;
    end else begin
      if ({1'b0, x_q} == ({1'b0, LEFT_PADDLE_X} + {1'b0, PADDLE_W}) && ovl_left) dx_d = 1'b1;
      else if (x_q == 9'd0) begin
        sr_d = sr_q + 4'd1;
        ps_d = 1'b1;
      end else x_d = x_q - 9'd1;
    end

    // respawn wins over the vertical step; serve heads toward the scorer
    if (ps_d) begin
      x_d  = START_X;
      y_d  = START_Y;
      dx_d = ~dx_q;
      dy_d = dy_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_WAIT_TRANSACTION;
      valid_q <= 1'b1;
      cnt_q   <= 32'd0;
      x_q     <= START_X;
      y_q     <= START_Y;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      sl_q    <= 4'd0;
      sr_q    <= 4'd0;
      ps_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      ps_q <= 1'b0;
      go_q <= go_q | (sl_q == WIN_SCORE) | (sr_q == WIN_SCORE);

      if (state_q == S_WAIT_TRANSACTION)   cnt_q <= 32'd0;
      else if (cnt_q != FRAME_RATE_COUNT)  cnt_q <= cnt_q + 32'd1;

      case (state_q)
        S_WAIT_TRANSACTION: begin
          if (bus.m_ready) begin
            state_q <= S_UPDATE_POSITION;
            valid_q <= 1'b0;
          end
        end
        S_UPDATE_POSITION: begin
          state_q <= S_WAIT_FRAME_RATE_COUNT;
          if (!go_q) begin
            x_q  <= x_d;
            y_q  <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            sl_q <= sl_d;
            sr_q <= sr_d;
            ps_q <= ps_d;
          end
        end
        S_WAIT_FRAME_RATE_COUNT: begin
          if (cnt_q == FRAME_RATE_COUNT) begin
            state_q <= S_WAIT_TRANSACTION;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_WAIT_TRANSACTION;
          valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.m_valid   = valid_q;
  assign bus.box_x     = x_q;
  assign bus.box_y     = y_q;
  assign bus.out_color = in_color;
  assign score_left    = sl_q;
  assign score_right   = sr_q;
  assign point_scored  = ps_q;
  assign game_over     = go_q;

endmodule

// File: doc/ball_location_processor.md
# ball_location_processor

Computes the Pong ball position once per frame: constant-speed diagonal motion, bounces off the top and bottom walls and both paddles, and scores when the ball reaches the left or right screen edge. Sits directly upstream of `screenDrawer`; it offers one ball box per frame on a valid/ready handshake, alongside the paddle location processors. Paddle Y positions come in from the two paddle processors, and the scores and game-over flag go out to the score display.

## Interface

**Parameters**
- `BALL_SIZE`, 9'd4: ball edge length in pixels (square).
- `SCREEN_WIDTH`, 9'd320: play-field width.
- `SCREEN_HEIGHT`, 9'd240: play-field height.
- `LEFT_PADDLE_X`, 9'd0: x of the left paddle's left edge.
- `RIGHT_PADDLE_X`, 9'd310: x of the right paddle's left edge.
- `PADDLE_W`, 9'd10: paddle width.
- `PADDLE_H`, 9'd48: paddle height.
- `START_X`, 9'd158: serve position x.
- `START_Y`, 9'd118: serve position y.
- `WIN_SCORE`, 4'd7: score that ends the game.
- `FRAME_RATE_COUNT`, 32'd3333332: frame pacing count.

**Ports**
- `clock`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high.
- `in_color`, input, 3: ball colour, passed straight through.
- `left_paddle_y`, input, 9: left paddle top y.
- `right_paddle_y`, input, 9: right paddle top y.
- `m_ready`, input, 1: downstream (`screenDrawer`) ready.
- `m_valid`, output, 1: ball box valid.
- `box_x`, output, 9: ball left x, registered.
- `box_y`, output, 9: ball top y, registered.
- `out_color`, output, 3: equals `in_color`.
- `score_left`, output, 4: left player score.
- `score_right`, output, 4: right player score.
- `point_scored`, output, 1: one-cycle pulse when a point is awarded.
- `game_over`, output, 1: set when either score equals `WIN_SCORE`.

## Operation

**States**
- `S_WAIT_TRANSACTION`: `m_valid`=1; the frame counter is held at 0. Moves to `S_UPDATE_POSITION` when `m_ready`=1.
- `S_UPDATE_POSITION`: one cycle; applies the update rules below. Always moves to `S_WAIT_FRAME_RATE_COUNT`.
- `S_WAIT_FRAME_RATE_COUNT`: moves to `S_WAIT_TRANSACTION` when the counter equals `FRAME_RATE_COUNT`.

**Frame counter**
- 32-bit.
- Increments outside `S_WAIT_TRANSACTION` and saturates at `FRAME_RATE_COUNT`.

**Direction registers**
- `dx` and `dy`: 1 = increasing coordinate.
- Reset values: `dx`=1, `dy`=1.

**Vertical update (per `S_UPDATE_POSITION`)**
- `dy`=1: if `box_y+BALL_SIZE==SCREEN_HEIGHT`, then `dy`←0 and y is unchanged; otherwise y+1.
- `dy`=0: if `box_y==0`, then `dy`←1 and y is unchanged; otherwise y−1.

**Paddle overlap**
- Condition: `box_y+BALL_SIZE > pad_y` AND `box_y < pad_y+PADDLE_H`.
- Computed in 10-bit unsigned arithmetic, so there is no wrap.

**Horizontal update**
- `dx`=1:
  - If `box_x+BALL_SIZE==RIGHT_PADDLE_X` and the ball overlaps the right paddle: `dx`←0, x unchanged.
  - Else if `box_x+BALL_SIZE==SCREEN_WIDTH`: left player scores.
  - Otherwise x+1.
- `dx`=0:
  - If `box_x==LEFT_PADDLE_X+PADDLE_W` and the ball overlaps the left paddle: `dx`←1, x unchanged.
  - Else if `box_x==0`: right player scores.
  - Otherwise x−1.

**Scoring**
- The scorer's score increments by 1 and `point_scored` pulses.
- The ball respawns at (`START_X`, `START_Y`); respawn overrides the vertical update that cycle.
- `dx` is inverted, so the serve goes toward the scorer. `dy` is unchanged.

**Simultaneous events**
- A wall bounce and a paddle bounce in the same update are both applied; each axis is independent.

**Game over**
- `game_over` is registered and set the cycle after a score reaches `WIN_SCORE`. It is cleared only by `reset`.
- While `game_over`=1, `S_UPDATE_POSITION` changes nothing (position, direction and scores are frozen), but the handshake and frame pacing continue.

**Paddle inputs**
- Sampled only in `S_UPDATE_POSITION`; no other timing requirement.

## Timing

**Reset values**
- State = `S_WAIT_TRANSACTION`, so `m_valid`=1 on the first cycle after reset.
- `box_x`=`START_X`, `box_y`=`START_Y`.
- Scores = 0, `point_scored`=0, `game_over`=0, counter = 0.
- Reset mid-operation, including mid-handshake, returns to exactly this state on the next edge.

**Handshake**
- A transfer occurs on any edge where `m_valid`=1 and `m_ready`=1.
- `box_x`, `box_y` and `out_color` are stable while `m_valid`=1.
- `m_valid` drops the cycle after the transfer.

**Update latency**
- New `box_x`/`box_y`, scores and `point_scored` appear one cycle after the `S_UPDATE_POSITION` cycle.
- `point_scored` lasts exactly one cycle.

**Frame period**
- From the transfer edge to the next `m_valid` rise: `FRAME_RATE_COUNT`+1 cycles.
- Plus any `m_ready` wait time.
- Exactly one update per transfer.

**Score width**
- Scores never exceed `WIN_SCORE`, which is ≤ 15.

## Test plan

All scenarios use: `SCREEN_WIDTH`=20, `SCREEN_HEIGHT`=16, `BALL_SIZE`=2, `LEFT_PADDLE_X`=0, `RIGHT_PADDLE_X`=18, `PADDLE_W`=2, `PADDLE_H`=4, `START`=(9,7), `FRAME_RATE_COUNT`=3, `WIN_SCORE`=2.

1. **Reset and pacing.** Assert `reset` for 2 cycles, hold `m_ready`=1.
   - `m_valid`=1 right after reset with box (9,7).
   - Next valid box is (10,8).
   - `m_valid` rises every 5 cycles (transfer edge plus `FRAME_RATE_COUNT`+1).
2. **Backpressure.** Hold `m_ready`=0 for 10 cycles.
   - `m_valid` stays 1 and the box stays constant.
   - No update occurs until `m_ready`=1.
3. **Wall bounce.** Run from (9,7) down-right until `box_y`=14.
   - The next update gives `box_y`=14 with `dy`=0.
   - The following update gives `box_y`=13.
4. **Paddle bounce.** `right_paddle_y`=10, ball at (16,12) with `dx`=1.
   - Next box is x=16; then x=15 (ball moving left).
   - Score unchanged, `point_scored`=0.
5. **Miss and score.** `right_paddle_y`=0, ball at (18,12) with `dx`=1.
   - `score_left`=1 and a single-cycle `point_scored` pulse.
   - Ball respawns at (9,7) with `dx`=0.
6. **Game over and reset.** Force a second left score.
   - `score_left`=2 and `game_over`=1.
   - Subsequent frames repeat (9,7) with scores frozen.
   - Assert `reset` mid-wait: everything returns to reset values.
